// File: rtl/maple_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maple_pkg
// Brief    : FSM state encodings and completion status codes shared by the
//            Maple Bus transaction scheduler and its arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package maple_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_TX_START = 3'd1;
  localparam logic [2:0] ST_TX       = 3'd2;
  localparam logic [2:0] ST_RX_WAIT  = 3'd3;
  localparam logic [2:0] ST_RX       = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef logic [1:0] status_t;

  localparam logic [1:0] STAT_OK           = 2'b00;
  localparam logic [1:0] STAT_RESP_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_TX_ERR       = 2'b10;
  localparam logic [1:0] STAT_RX_ABORT     = 2'b11;

  // The bus is turned around to the receiver only while waiting for or taking a reply.
  function automatic logic is_rx_state(input state_t st);
    return (st == ST_RX_WAIT) || (st == ST_RX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maple_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : maple_rr_arbiter
// Brief    : Combinational one-hot round-robin pick: first request at or after
//            the pointer, wrapping to 0. Idle requesters are skipped.
// Revision : 1.0 - initial release
// ============================================================================
module maple_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = ID_W'(idx);
      if (!gnt_any && req[idx_w]) begin
        gnt_any    = 1'b1;
        gnt_id     = idx_w;
        gnt[idx_w] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/maple_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : maple_txn_scheduler
// Brief    : Grants one Maple Bus frame at a time, supervises TX, bus turnaround
//            and the reply window, and reports a completion record per txn.
// Revision : 1.0 - initial release
// ============================================================================
module maple_txn_scheduler
  import maple_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int START_TO = 256,
  parameter int RESP_TO  = 100000,
  parameter int CNT_W    = 17
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_expect_resp,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               rx_enable,
  input  logic               rx_active,
  input  logic               rx_last,
  output logic               done_valid,
  output logic [ID_W-1:0]    done_id,
  output logic [1:0]         done_status,
  input  logic               done_ready
);

  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] RESP_LIM  = CNT_W'(RESP_TO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 expect_q, expect_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  status_t              status_q, status_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_start_q, tx_start_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_any;
  logic [CNT_W-1:0]     cnt_inc;

  maple_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id),
    .gnt_any (arb_any)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    expect_d    = expect_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && arb_any) begin
          id_d        = arb_id;
          expect_d    = req_expect_resp[arb_id];
          ptr_d       = (int'(arb_id) == NUM_REQ - 1) ? '0 : arb_id + ID_W'(1);
          req_ready_d = arb_gnt;
          tx_start_d  = 1'b1;
          cnt_d       = '0;
          state_d     = ST_TX_START;
        end
      end

      ST_TX_START: begin
        if (tx_busy) begin
          state_d = ST_TX;
        end else if (cnt_q >= START_LIM) begin
          status_d = STAT_TX_ERR;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_TX: begin
        if (!tx_busy) begin
          if (expect_q) begin
            // The cycle tx_busy is first seen low already counts toward the reply window.
            cnt_d   = CNT_W'(1);
            state_d = ST_RX_WAIT;
          end else begin
            status_d = STAT_OK;
            state_d  = ST_DONE;
          end
        end
      end

      ST_RX_WAIT: begin
        if (rx_active) begin
          state_d = ST_RX;
        end else if (cnt_q >= RESP_LIM) begin
          status_d = STAT_RESP_TIMEOUT;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RX: begin
        // A final beat coinciding with the receiver dropping is still a clean reply.
        if (rx_last) begin
          status_d = STAT_OK;
          state_d  = ST_DONE;
        end else if (!rx_active) begin
          status_d = STAT_RX_ABORT;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      expect_q    <= 1'b0;
      cnt_q       <= '0;
      status_q    <= STAT_OK;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      expect_q    <= expect_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign grant_id    = id_q;
  assign busy        = (state_q != ST_IDLE);
  assign rx_enable   = is_rx_state(state_q);
  assign done_valid  = (state_q == ST_DONE);
  assign done_id     = id_q;
  assign done_status = status_q;

endmodule
`default_nettype wire

// File: tb/tb_maple_txn_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_maple_txn_scheduler
// Brief    : Self-checking bench for maple_txn_scheduler with a cycle-level
//            transaction reference model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maple_txn_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int START_TO = 32;
  localparam int RESP_TO  = 300;
  localparam int CNT_W    = 9;

  logic               aclk = 1'b0;
  logic               areset;
  logic               enable;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_expect_resp;
  logic [NUM_REQ-1:0] req_ready;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               tx_start;
  logic               tx_busy;
  logic               rx_enable;
  logic               rx_active;
  logic               rx_last;
  logic               done_valid;
  logic [ID_W-1:0]    done_id;
  logic [1:0]         done_status;
  logic               done_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int model_ptr = 0;

  typedef struct packed {
    int gid; int exp_gid; int gcyc; int dcyc; int acyc; int exp_lat;
    int did; int dst; int exp_st; int rxen_bad; int pulse_bad;
    int busy_bad; int unstable; int acc_bad; int timeout;
  } txn_t;

  maple_txn_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .ID_W     (ID_W),
    .START_TO (START_TO),
    .RESP_TO  (RESP_TO),
    .CNT_W    (CNT_W)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .enable          (enable),
    .req_valid       (req_valid),
    .req_expect_resp (req_expect_resp),
    .req_ready       (req_ready),
    .grant_id        (grant_id),
    .busy            (busy),
    .tx_start        (tx_start),
    .tx_busy         (tx_busy),
    .rx_enable       (rx_enable),
    .rx_active       (rx_active),
    .rx_last         (rx_last),
    .done_valid      (done_valid),
    .done_id         (done_id),
    .done_status     (done_status),
    .done_ready      (done_ready)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] all_outputs();
    return {req_ready, grant_id, busy, tx_start, rx_enable, done_valid, done_id, done_status};
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [3:0] rv);
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (model_ptr + i) % NUM_REQ;
      if (((rv >> k) & 4'd1) != 4'd0) return k;
    end
    return -1;
  endfunction

  // Drives one transaction with a scripted transmitter/receiver and records what the DUT did.
  // bdly<0: transmitter never starts. rxk: 0 none, 1 last then drop, 2 abort, 3 last with drop.
  task automatic do_txn(input logic [3:0] rv, input logic [3:0] ex, input int bdly, input int blen,
                        input int rxk, input int rrise, input int rlast, input int hold,
                        output txn_t r);
    int g, f, dexp, c;
    bit exp_r, seen, acc;
    logic [1:0] eg;
    logic [3:0] oh_exp;
    r = '0;
    r.exp_gid = model_pick(rv);
    model_ptr = (r.exp_gid + 1) % NUM_REQ;
    eg     = 2'(r.exp_gid);
    oh_exp = 4'(1) << eg;
    exp_r  = ex[eg];
    req_valid = rv; req_expect_resp = ex; enable = 1'b1;
    tx_busy = 1'b0; rx_active = 1'b0; rx_last = 1'b0; done_ready = 1'b0;
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (tx_start === 1'b1) begin g = cyc; break; end
    end
    if (g < 0) begin r.timeout = 1; req_valid = '0; return; end
    r.gcyc = g; r.gid = -1;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready === (4'(1) << i)) r.gid = i;
    if (bdly < 0) begin
      f = -1; dexp = g + START_TO; r.exp_st = 2;
    end else begin
      f = g + bdly + blen;
      if (!exp_r)         begin dexp = f + 1;       r.exp_st = 0; end
      else if (rxk == 0)  begin dexp = f + RESP_TO; r.exp_st = 1; end
      else                begin dexp = f + rlast + 1; r.exp_st = (rxk == 2) ? 3 : 0; end
    end
    r.exp_lat = dexp - g;
    seen = 0; acc = 0; r.dcyc = -1; r.acyc = -1;
    for (int n = 0; n < START_TO + RESP_TO + rlast + hold + 100; n++) begin
      c = cyc;
      if (seen && c == r.acyc + 1) begin
        if (done_valid !== 1'b0 || busy !== 1'b0) r.acc_bad += 1;
        acc = 1; done_ready = 1'b0; req_valid = '0;
        break;
      end
      if (tx_start !== (c == g) || req_ready !== ((c == g) ? oh_exp : 4'b0)) r.pulse_bad += 1;
      if (rx_enable !== (exp_r && f >= 0 && c > f && c < dexp)) r.rxen_bad += 1;
      if (busy !== 1'b1 || grant_id !== eg) r.busy_bad += 1;
      if (done_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; r.dcyc = c; r.did = int'(done_id); r.dst = int'(done_status); r.acyc = c + hold;
        end else if (done_id !== 2'(r.did) || done_status !== 2'(r.dst)) begin
          r.unstable += 1;
        end
      end else if (seen) begin
        r.unstable += 1;
      end
      tx_busy   = (bdly >= 0) && (c >= g + bdly) && (c < g + bdly + blen);
      rx_active = exp_r && (f >= 0) && (rxk != 0) && (c >= f + rrise) &&
                  ((rxk == 1) ? (c <= f + rlast) : (c < f + rlast));
      rx_last   = exp_r && (f >= 0) && (rxk == 1 || rxk == 3) && (c == f + rlast);
      if (seen) begin
        req_valid = '0; enable = 1'b1; done_ready = (c == r.acyc);
      end else begin
        req_valid = 4'($urandom); enable = 1'($urandom); done_ready = 1'($urandom);
      end
      @(negedge aclk);
    end
    if (!acc) r.timeout = 1;
    tx_busy = 1'b0; rx_active = 1'b0; rx_last = 1'b0; done_ready = 1'b0;
    req_valid = '0; enable = 1'b1;
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b1; req_valid = 4'hF; req_expect_resp = 4'hF;
    tx_busy = 1'b1; rx_active = 1'b1; rx_last = 1'b1; done_ready = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if (all_outputs() !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", all_outputs());
    end
    req_valid = '0; req_expect_resp = '0; tx_busy = 1'b0; rx_active = 1'b0;
    rx_last = 1'b0; done_ready = 1'b0; areset = 1'b0; model_ptr = 0;
    @(negedge aclk);
    checks++;
    if (all_outputs() !== 14'd0) begin
      errors++; $display("FAIL reset_idle got=%h want=0", all_outputs());
    end
  endtask

  task automatic test_single();
    txn_t r;
    do_txn(4'b0001, 4'b0000, 1, 10, 0, 0, 0, 0, r);
    checks++;
    if (r.timeout != 0 || r.gid != 0 || r.did != 0) begin
      errors++; $display("FAIL single_id timeout=%0d gid=%0d did=%0d want 0/0/0", r.timeout, r.gid, r.did);
    end
    checks++;
    if (r.dst != 0 || r.dcyc - r.gcyc != 12) begin
      errors++; $display("FAIL single_done status=%0d lat=%0d want 0/12", r.dst, r.dcyc - r.gcyc);
    end
    checks++;
    if (r.pulse_bad + r.rxen_bad + r.busy_bad + r.unstable + r.acc_bad != 0) begin
      errors++; $display("FAIL single_protocol pulse=%0d rxen=%0d busy=%0d unstable=%0d acc=%0d want 0",
                         r.pulse_bad, r.rxen_bad, r.busy_bad, r.unstable, r.acc_bad);
    end
  endtask

  task automatic test_min_latency();
    txn_t r;
    do_txn(4'b0010, 4'b0000, 1, 1, 0, 0, 0, 0, r);
    checks++;
    if (r.timeout != 0 || r.dcyc - r.gcyc != 3 || r.dst != 0) begin
      errors++; $display("FAIL min_latency lat=%0d status=%0d want 3/0", r.dcyc - r.gcyc, r.dst);
    end
  endtask

  task automatic test_round_robin();
    txn_t r;
    int want[8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    logic [3:0] masks[8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA, 4'hA};
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_txn(masks[i], 4'b0000, 1, 2, 0, 0, 0, 0, r);
      checks++;
      if (r.timeout != 0 || r.gid != want[i] || r.did != want[i]) begin
        errors++; $display("FAIL rr_grant[%0d] gid=%0d did=%0d want %0d", i, r.gid, r.did, want[i]);
      end
    end
  endtask

  task automatic test_tx_error();
    txn_t r;
    do_txn(4'b0100, 4'b0100, -1, 0, 0, 0, 0, 2, r);
    checks++;
    if (r.timeout != 0 || r.dst != 2 || r.dcyc - r.gcyc != START_TO) begin
      errors++; $display("FAIL tx_error status=%0d lat=%0d want 2/%0d", r.dst, r.dcyc - r.gcyc, START_TO);
    end
    checks++;
    if (r.rxen_bad != 0 || r.pulse_bad != 0) begin
      errors++; $display("FAIL tx_error_rxen rxen_bad=%0d pulse_bad=%0d want 0", r.rxen_bad, r.pulse_bad);
    end
  endtask

  task automatic test_resp_timeout();
    txn_t r;
    do_txn(4'b1000, 4'b1000, 2, 5, 0, 0, 0, 1, r);
    checks++;
    if (r.timeout != 0 || r.dst != 1 || r.dcyc - (r.gcyc + 7) != RESP_TO) begin
      errors++; $display("FAIL resp_timeout status=%0d after_fall=%0d want 1/%0d",
                         r.dst, r.dcyc - (r.gcyc + 7), RESP_TO);
    end
    checks++;
    if (r.rxen_bad != 0) begin
      errors++; $display("FAIL resp_timeout_rxen rxen_bad=%0d want 0", r.rxen_bad);
    end
  endtask

  task automatic test_rx_path();
    txn_t r;
    int kind[3] = '{1, 2, 3};
    int want[3] = '{0, 3, 0};
    int lastc[3] = '{200, 120, 90};
    for (int i = 0; i < 3; i++) begin
      do_txn(4'b1111, 4'b1111, 1, 4, kind[i], 50, lastc[i], 0, r);
      checks++;
      if (r.timeout != 0 || r.dst != want[i] || r.dcyc - r.gcyc != 1 + 4 + lastc[i] + 1) begin
        errors++; $display("FAIL rx_path[%0d] status=%0d lat=%0d want %0d/%0d",
                           i, r.dst, r.dcyc - r.gcyc, want[i], 6 + lastc[i]);
      end
      checks++;
      if (r.rxen_bad != 0 || r.busy_bad != 0) begin
        errors++; $display("FAIL rx_path_enable[%0d] rxen_bad=%0d busy_bad=%0d want 0", i, r.rxen_bad, r.busy_bad);
      end
    end
  endtask

  task automatic test_done_hold();
    txn_t r;
    do_txn(4'b0110, 4'b0000, 1, 3, 0, 0, 0, 20, r);
    checks++;
    if (r.timeout != 0 || r.unstable != 0 || r.acc_bad != 0 || r.did != r.exp_gid) begin
      errors++; $display("FAIL done_hold unstable=%0d acc_bad=%0d did=%0d want 0/0/%0d",
                         r.unstable, r.acc_bad, r.did, r.exp_gid);
    end
  endtask

  task automatic test_back_to_back();
    txn_t r1, r2;
    do_txn(4'b0011, 4'b0000, 1, 1, 0, 0, 0, 0, r1);
    do_txn(4'b0011, 4'b0000, 1, 1, 0, 0, 0, 0, r2);
    checks++;
    if (r1.timeout != 0 || r2.timeout != 0 || r2.gcyc != r1.acyc + 2 || r2.gid != r2.exp_gid) begin
      errors++; $display("FAIL back_to_back grant_cyc=%0d want %0d gid=%0d want %0d",
                         r2.gcyc, r1.acyc + 2, r2.gid, r2.exp_gid);
    end
  endtask

  task automatic test_reset_mid_rx();
    int g = -1;
    req_valid = 4'b0001; req_expect_resp = 4'b0001; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (tx_start === 1'b1) begin g = cyc; break; end
    end
    req_valid = '0;
    @(negedge aclk); tx_busy = 1'b1;
    @(negedge aclk); tx_busy = 1'b0;
    repeat (2) @(negedge aclk); rx_active = 1'b1;
    repeat (5) @(negedge aclk);
    checks++;
    if (g < 0 || rx_enable !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rstrx_in_rx grant=%0d rx_enable=%b busy=%b want 1/1", g, rx_enable, busy);
    end
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if (all_outputs() !== 14'd0) begin
      errors++; $display("FAIL rstrx_cleared got=%h want=0", all_outputs());
    end
    areset = 1'b0; rx_active = 1'b0; model_ptr = 0;
    @(negedge aclk);
  endtask

  task automatic test_reset_pending_done();
    txn_t r;
    int seen = 0;
    req_valid = 4'b0100; req_expect_resp = 4'b0000; enable = 1'b1; done_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      req_valid = '0;
      tx_busy = (tx_start === 1'b1);
      if (done_valid === 1'b1) begin seen = 1; break; end
    end
    tx_busy = 1'b0;
    repeat (5) @(negedge aclk);
    checks++;
    if (seen == 0 || done_valid !== 1'b1 || done_id !== 2'd2) begin
      errors++; $display("FAIL pend_done seen=%0d valid=%b id=%0d want 1/1/2", seen, done_valid, done_id);
    end
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0; model_ptr = 0;
    checks++;
    if (all_outputs() !== 14'd0) begin
      errors++; $display("FAIL pend_reset got=%h want=0", all_outputs());
    end
    @(negedge aclk);
    do_txn(4'b1111, 4'b0000, 1, 1, 0, 0, 0, 0, r);
    checks++;
    if (r.timeout != 0 || r.gid != 0) begin
      errors++; $display("FAIL pend_ptr_reset gid=%0d want 0", r.gid);
    end
  endtask

  task automatic test_random();
    txn_t r;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] rv, ex;
      int bdly, blen, rxk, rrise, rlast, hold;
      rv    = 4'($urandom_range(1, 15));
      ex    = 4'($urandom);
      bdly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 4));
      blen  = int'($urandom_range(1, 20));
      rxk   = int'($urandom_range(0, 3));
      rrise = int'($urandom_range(1, 60));
      rlast = rrise + int'($urandom_range(1, 40));
      hold  = int'($urandom_range(0, 5));
      do_txn(rv, ex, bdly, blen, rxk, rrise, rlast, hold, r);
      checks++;
      if (r.timeout != 0 || r.gid != r.exp_gid || r.did != r.exp_gid) begin
        errors++; $display("FAIL rand_grant[%0d] timeout=%0d gid=%0d did=%0d want %0d",
                           i, r.timeout, r.gid, r.did, r.exp_gid);
      end
      checks++;
      if (r.dst != r.exp_st || r.dcyc - r.gcyc != r.exp_lat) begin
        errors++; $display("FAIL rand_done[%0d] status=%0d lat=%0d want %0d/%0d",
                           i, r.dst, r.dcyc - r.gcyc, r.exp_st, r.exp_lat);
      end
      checks++;
      if (r.pulse_bad + r.rxen_bad + r.busy_bad + r.unstable + r.acc_bad != 0) begin
        errors++; $display("FAIL rand_protocol[%0d] pulse=%0d rxen=%0d busy=%0d unstable=%0d acc=%0d want 0",
                           i, r.pulse_bad, r.rxen_bad, r.busy_bad, r.unstable, r.acc_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_min_latency();
    test_round_robin();
    test_tx_error();
    test_resp_timeout();
    test_rx_path();
    test_done_hold();
    test_back_to_back();
    test_reset_mid_rx();
    test_reset_pending_done();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
